// File: rtl/pulse_dec_pkg.sv
// Shared types for the pulse width decoder: FSM states, result codes and
// the length classification rule.
package pulse_dec_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OK    = 2'd0,
      SHORT = 2'd1,
      LONG  = 2'd2
   } err_t;

   function automatic err_t classify(input int len, input int min_len, input int max_len);
      if (len < min_len)
         return SHORT;
      else if (len > max_len)
         return LONG;
      else
         return OK;
   endfunction

endpackage

// File: rtl/pulse_width_decoder_if.sv
// Result handshake between the decoder (master) and its consumer (slave).
interface pulse_width_decoder_if #(
   parameter int CNT_W = 5
) ();
   import pulse_dec_pkg::*;

   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] meas_len;
   err_t             meas_err;

   modport master (
      output meas_valid,
      output meas_len,
      output meas_err,
      input  meas_ready
   );

   modport slave (
      input  meas_valid,
      input  meas_len,
      input  meas_err,
      output meas_ready
   );
endinterface

// File: rtl/pulse_edge_det.sv
// Rising-edge detector on an already-synchronous input.
// RST_VAL=1 keeps a level that is already high at reset release from looking like a rise.
module pulse_edge_det #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_din,
   output logic o_rise
);

   logic r_din_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_din_q <= RST_VAL;
      else
         r_din_q <= i_din;
   end

   assign o_rise = i_din & ~r_din_q;

endmodule

// File: rtl/pulse_width_decoder.sv
// Measures the high time of din in clk cycles and offers each result through
// a one-deep valid/ready slot; results finishing while the slot is blocked are dropped.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a rise of din while en is high
//   MEASURE | counting cycles with din high; din low finishes, en low abandons
module pulse_width_decoder
   import pulse_dec_pkg::*;
#(
   parameter int MIN_LEN = 2,
   parameter int MAX_LEN = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  din,
   output logic                  active,
   output logic                  drop,
   pulse_width_decoder_if.master bus
);

   localparam int               CNT_W   = $clog2(MAX_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_LEN + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_rise;
   logic             w_start;
   logic             w_finish;
   logic             w_hs;
   err_t             w_err;

   pulse_edge_det #(
      .RST_VAL (1'b1)
   ) u_edge_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (din),
      .o_rise (w_rise)
   );

   assign w_start  = (r_state == IDLE) && en && w_rise;
   assign w_finish = (r_state == MEASURE) && en && !din;
   assign w_hs     = bus.meas_valid && bus.meas_ready;
   assign w_err    = classify(32'(r_cnt), MIN_LEN, MAX_LEN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (en && w_rise)
               w_state_nxt = MEASURE;
         end
         MEASURE: begin
            if (!en || !din)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      active = (r_state == MEASURE);
   end

   // The rise cycle itself counts as the first high sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (w_start)
         r_cnt <= CNT_W'(1);
      else if ((r_state == MEASURE) && en && din && (r_cnt != CNT_SAT))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   // A result may replace the held one only when that one is leaving this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.meas_valid <= 1'b0;
         bus.meas_len   <= '0;
         bus.meas_err   <= OK;
         drop           <= 1'b0;
      end else begin
         drop <= 1'b0;
         if (w_finish) begin
            if (!bus.meas_valid || bus.meas_ready) begin
               bus.meas_valid <= 1'b1;
               bus.meas_len   <= r_cnt;
               bus.meas_err   <= w_err;
            end else begin
               drop <= 1'b1;
            end
         end else if (w_hs) begin
            bus.meas_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder: directed scenarios plus random din/en/ready.
module tb_pulse_width_decoder;
   import pulse_dec_pkg::*;

   localparam int MIN_LEN = 2;
   localparam int MAX_LEN = 16;
   localparam int CNT_W   = $clog2(MAX_LEN + 2);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic din   = 1'b0;
   logic active;
   logic drop;

   pulse_width_decoder_if #(.CNT_W(CNT_W)) bus ();

   pulse_width_decoder #(
      .MIN_LEN (MIN_LEN),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .din    (din),
      .active (active),
      .drop   (drop),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   len;
      err_t err;
   } res_t;

   res_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a measurement is the run of high samples that starts at an
   // enabled rise; its length is that run's count, reported saturated.
   bit   m_prev  = 1'b1;
   bit   m_meas  = 1'b0;
   bit   m_valid = 1'b0;
   bit   m_drop  = 1'b0;
   int   m_ones  = 0;
   bit   m_fin;
   bit   m_rise;
   bit   m_hs;
   res_t m_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev  = 1'b1;
         m_meas  = 1'b0;
         m_ones  = 0;
         m_valid = 1'b0;
         m_drop  = 1'b0;
         exp_q.delete();
      end else begin
         m_fin  = 1'b0;
         m_hs   = m_valid && bus.meas_ready;
         m_rise = din && !m_prev;
         m_prev = din;
         if (m_meas) begin
            if (!en)
               m_meas = 1'b0;
            else if (din)
               m_ones++;
            else begin
               m_fin  = 1'b1;
               m_meas = 1'b0;
            end
         end else if (en && m_rise) begin
            m_meas = 1'b1;
            m_ones = 1;
         end
         m_drop = 1'b0;
         if (m_fin) begin
            m_res.len = (m_ones > MAX_LEN) ? MAX_LEN + 1 : m_ones;
            m_res.err = (m_ones < MIN_LEN) ? SHORT : (m_ones > MAX_LEN) ? LONG : OK;
            if (!m_valid || bus.meas_ready) begin
               exp_q.push_back(m_res);
               m_valid = 1'b1;
            end else begin
               m_drop = 1'b1;
            end
         end else if (m_hs) begin
            m_valid = 1'b0;
         end
      end
   end

   // Monitor: checks the held result against the scoreboard and pops on handshake.
   int n_pop    = 0;
   int n_drop   = 0;
   int n_active = 0;
   int last_len = -1;
   int last_err = -1;

   always @(negedge clk) begin
      chk("meas_valid", int'(bus.meas_valid), int'(m_valid));
      chk("active", int'(active), int'(m_meas));
      chk("drop", int'(drop), int'(m_drop));
      if (!rst_n) begin
         chk("rst_len", int'(bus.meas_len), 0);
         chk("rst_err", int'(bus.meas_err), int'(OK));
      end
      if (drop)   n_drop++;
      if (active) n_active++;
      if (bus.meas_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            chk("meas_len", int'(bus.meas_len), exp_q[0].len);
            chk("meas_err", int'(bus.meas_err), int'(exp_q[0].err));
            if (bus.meas_ready) begin
               last_len = int'(bus.meas_len);
               last_err = int'(bus.meas_err);
               n_pop++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      din = 1'b1;
      step(hi);
      din = 1'b0;
      step(lo);
   endtask

   int base;
   int base_d;
   int base_a;

   initial begin
      bus.meas_ready = 1'b1;
      step(3);
      chk("rst_valid_direct", int'(bus.meas_valid), 0);
      chk("rst_active_direct", int'(active), 0);
      chk("rst_drop_direct", int'(drop), 0);
      rst_n = 1'b1;
      en    = 1'b1;
      step(3);

      // nominal pulse, ready high
      base = n_pop;
      pulse(6, 4);
      chk("ok6_count", n_pop - base, 1);
      chk("ok6_len", last_len, 6);
      chk("ok6_err", last_err, int'(OK));

      // single-cycle pulse
      base = n_pop;
      pulse(1, 4);
      chk("short1_count", n_pop - base, 1);
      chk("short1_len", last_len, 1);
      chk("short1_err", last_err, int'(SHORT));

      // long pulse saturates
      base   = n_pop;
      base_a = n_active;
      pulse(20, 4);
      chk("long20_active_cycles", n_active - base_a, 20);
      chk("long20_len", last_len, MAX_LEN + 1);
      chk("long20_err", last_err, int'(LONG));

      // blocked consumer: second result dropped
      base   = n_pop;
      base_d = n_drop;
      bus.meas_ready = 1'b0;
      pulse(3, 2);
      pulse(5, 2);
      chk("blocked_drop_count", n_drop - base_d, 1);
      chk("blocked_pop_count", n_pop - base, 0);
      bus.meas_ready = 1'b1;
      step(2);
      chk("blocked_consumed", n_pop - base, 1);
      chk("blocked_len", last_len, 3);
      chk("blocked_valid_after", int'(bus.meas_valid), 0);

      // enable dropped mid-pulse, din still high on re-enable
      base = n_pop;
      din  = 1'b1;
      step(3);
      en = 1'b0;
      step(2);
      en = 1'b1;
      step(3);
      din = 1'b0;
      step(4);
      chk("en_gap_no_result", n_pop - base, 0);
      pulse(4, 4);
      chk("en_gap_next_count", n_pop - base, 1);
      chk("en_gap_next_len", last_len, 4);

      // reset mid-pulse, din high at release
      base = n_pop;
      din  = 1'b1;
      step(3);
      rst_n = 1'b0;
      #1;
      chk("midrst_active", int'(active), 0);
      chk("midrst_valid", int'(bus.meas_valid), 0);
      step(2);
      rst_n = 1'b1;
      step(3);
      din = 1'b0;
      step(3);
      chk("midrst_no_result", n_pop - base, 0);
      pulse(5, 4);
      chk("midrst_next_len", last_len, 5);

      // back-to-back pulses with a single low cycle between
      base = n_pop;
      pulse(3, 1);
      pulse(2, 4);
      chk("b2b_count", n_pop - base, 2);
      chk("b2b_last_len", last_len, 2);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         en             = ($urandom_range(0, 19) != 0);
         bus.meas_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0)
            din = ~din;
         else if ($urandom_range(0, 99) == 0)
            din = 1'b1;
         step(1);
      end

      // drain
      en             = 1'b1;
      din            = 1'b0;
      bus.meas_ready = 1'b1;
      step(25);
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("drain_valid", int'(bus.meas_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_width_decoder.md
PULSE_WIDTH_DECODER -- requirements
Module: pulse_width_decoder

Interface
REQ-001 SHALL have parameter MIN_LEN, default 2: shortest accepted pulse, in clk cycles; 1 <= MIN_LEN <= MAX_LEN.
REQ-002 SHALL have parameter MAX_LEN, default 16: longest accepted pulse, in clk cycles.
REQ-003 SHALL derive localparam CNT_W = $clog2(MAX_LEN+2): width of the length field.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1: decoder enable.
REQ-007 SHALL have port din, input, 1: pulse input, already synchronous to clk (e.g. one_shot y).
REQ-008 SHALL have port meas_valid, output, 1: a result is held.
REQ-009 SHALL have port meas_ready, input, 1: the consumer accepts the result.
REQ-010 SHALL have port meas_len, output, CNT_W: measured high length, saturating at MAX_LEN+1.
REQ-011 SHALL have port meas_err, output, 2: result code, one of OK, SHORT, LONG.
REQ-012 SHALL have port active, output, 1: a measurement is in progress.
REQ-013 SHALL have port drop, output, 1: one-cycle pulse when a finished result is discarded.

Function
REQ-014 SHALL register din into din_q each cycle; rise = din & ~din_q.
REQ-015 SHALL implement FSM IDLE/MEASURE; active = (state == MEASURE).
REQ-016 SHALL, in IDLE with en and rise, load cnt to 1 and go to MEASURE.
REQ-017 SHALL, in MEASURE with din=1, increment cnt, saturating at MAX_LEN+1.
REQ-018 SHALL, in MEASURE with din=0, finish the measurement at that posedge and return to IDLE.
REQ-019 SHALL make the measured length equal the number of posedges at which din was sampled 1, starting at the rise.
REQ-020 SHALL code the finished result SHORT if cnt < MIN_LEN, LONG if cnt > MAX_LEN, and OK otherwise.
REQ-021 SHALL register the result into the output slot at the finishing posedge, so meas_valid is high from the next cycle.
REQ-022 SHALL complete the handshake when meas_valid & meas_ready at a posedge, clearing meas_valid unless a new result loads in the same cycle.
REQ-023 SHALL hold meas_len and meas_err stable while meas_valid & ~meas_ready.
REQ-024 SHALL, on a finishing posedge while meas_valid & ~meas_ready, discard the new result, keep the held one, and assert drop for exactly one cycle.
REQ-025 SHALL, on a finishing posedge while meas_valid & meas_ready, load the new result with meas_valid staying high and no drop.
REQ-026 SHALL, when en=0, force IDLE and abandon any in-progress measurement with no result and no drop; the output slot and handshake stay fully functional.
REQ-027 SHALL not start a measurement while din stays high after en rises; only a new rise starts one.
REQ-028 SHALL never report a pulse whose rise and end fall in the same cycle; the minimum reported length is 1.
REQ-029 SHALL accept a new rise on the cycle immediately after a finishing cycle.

Reset
REQ-030 SHALL asynchronously set state=IDLE, cnt=0, meas_valid=0, meas_len=0, meas_err=OK and drop=0 while rst_n=0.
REQ-031 SHALL reset din_q to 1, so a pulse already high at reset release is ignored.
REQ-032 SHALL discard, with no report, any measurement in progress when reset asserts.

Structure
REQ-033 SHALL place the state enum (IDLE, MEASURE) and err-code enum (OK=0, SHORT=1, LONG=2) in shared package pulse_dec_pkg.
REQ-034 SHALL implement edge detection (din_q, rise) as sub-module pulse_edge_det, with parameter RST_VAL, default 1.

Verification
REQ-035 SHALL cover: one_shot PULSE_LEN=6 driving din, meas_ready=1 -> exactly one result, len=6, OK, meas_valid high one cycle.
REQ-036 SHALL cover: din high 1 cycle, MIN_LEN=2 -> len=1, SHORT.
REQ-037 SHALL cover: din high 20 cycles, MAX_LEN=16 -> len=17, LONG; active high for exactly 20 cycles.
REQ-038 SHALL cover: meas_ready=0, pulses of 3 then 5 cycles -> len=3 held stable, drop pulses once at the second pulse's end, and raising ready -> len=3 consumed, meas_valid=0.
REQ-039 SHALL cover: en=0 for 2 cycles mid-pulse, re-enabled while din still high -> no result until the next rise, which then reports its correct length.
REQ-040 SHALL cover: rst_n low mid-pulse, with din still high at release -> all outputs 0/OK and no result until din goes low then high.
